// File: rtl/jingle_player.sv
// rtl/jingle_player.sv - success/fail melody sequencer driving piezo tone code and LED mirror.
// Optional feature: define JINGLE_RETRIGGER_EN to let a trigger restart a running jingle.
module jingle_player #(
    parameter int CLK_DIV    = 5000000,
    parameter int NOTE_TICKS = 2,
    parameter int GAP_TICKS  = 2,
    parameter int MAX_LEN    = 8,
    parameter int LEN_W      = 4,
    parameter int NOTE_W     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              success,
    input  logic              fail,
    input  logic [LEN_W-1:0]  melody_len,
    output logic [NOTE_W-1:0] piezo_out,
    output logic [NOTE_W-1:0] led_out,
    output logic              busy,
    output logic              done
);

    localparam int DIV_W    = $clog2(CLK_DIV);
    localparam int TICK_MAX = (NOTE_TICKS > GAP_TICKS) ? NOTE_TICKS : GAP_TICKS;
    localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [TICK_W-1:0] NOTE_LAST = TICK_W'(NOTE_TICKS - 1);
    localparam logic [TICK_W-1:0] GAP_LAST  = TICK_W'(GAP_TICKS - 1);
    localparam logic [LEN_W-1:0]  MAX_L     = LEN_W'(MAX_LEN);

`ifdef JINGLE_RETRIGGER_EN
    localparam logic RETRIGGER = 1'b1;
`else
    localparam logic RETRIGGER = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NOTE = 2'd1,
        GAP  = 2'd2
    } state_t;

    state_t             state;
    logic               mode_fail;
    logic [LEN_W-1:0]   len_q;
    logic [LEN_W-1:0]   idx;
    logic [DIV_W-1:0]   div_cnt;
    logic [TICK_W-1:0]  tick_cnt;

    logic               trigger;
    logic               accept;
    logic               tick_end;
    logic [LEN_W-1:0]   start_len;

    // Success climbs 1..L; fail descends L+1..2.
    function automatic logic [NOTE_W-1:0] tone_of(input logic m_fail,
                                                  input logic [LEN_W-1:0] l,
                                                  input logic [LEN_W-1:0] k);
        if (m_fail)
            return NOTE_W'(l) + NOTE_W'(1) - NOTE_W'(k);
        else
            return NOTE_W'(k) + NOTE_W'(1);
    endfunction

    always_comb begin
        trigger  = success | fail;
        accept   = trigger & ((state == IDLE) | RETRIGGER);
        tick_end = (div_cnt == DIV_LAST);
        if (melody_len == '0)
            start_len = LEN_W'(1);
        else if (melody_len > MAX_L)
            start_len = MAX_L;
        else
            start_len = melody_len;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            mode_fail <= 1'b0;
            len_q     <= '0;
            idx       <= '0;
            div_cnt   <= '0;
            tick_cnt  <= '0;
            piezo_out <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                state     <= NOTE;
                mode_fail <= fail;
                len_q     <= start_len;
                idx       <= '0;
                div_cnt   <= '0;
                tick_cnt  <= '0;
                piezo_out <= tone_of(fail, start_len, '0);
                busy      <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        div_cnt  <= '0;
                        tick_cnt <= '0;
                    end
                    NOTE: begin
                        div_cnt <= tick_end ? '0 : div_cnt + 1'b1;
                        if (tick_end) begin
                            if (tick_cnt == NOTE_LAST) begin
                                tick_cnt  <= '0;
                                state     <= GAP;
                                piezo_out <= '0;
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    GAP: begin
                        div_cnt <= tick_end ? '0 : div_cnt + 1'b1;
                        if (tick_end) begin
                            if (tick_cnt == GAP_LAST) begin
                                tick_cnt <= '0;
                                if (idx == len_q - 1'b1) begin
                                    state <= IDLE;
                                    busy  <= 1'b0;
                                    done  <= 1'b1;
                                    idx   <= '0;
                                end else begin
                                    state     <= NOTE;
                                    idx       <= idx + 1'b1;
                                    piezo_out <= tone_of(mode_fail, len_q, idx + 1'b1);
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign led_out = piezo_out;

endmodule
